// File: rtl/audio_seq_pkg.sv
// Shared types and default widths for the audio sample-address sequencer.
// MULTI_ADDR_SEQ_PINGPONG_EN enables the PINGPONG play mode.
package audio_seq_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_NUM_CH = 4;

    typedef enum logic [1:0] {
        ONESHOT  = 2'b00,
        LOOP     = 2'b01,
        PINGPONG = 2'b10,
        RSVD     = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN_UP   = 2'b01,
        RUN_DOWN = 2'b10
    } seq_state_t;

    // Map the requested mode onto the behaviour this build supports.
    // Reserved and (when not built) PINGPONG both fall back to LOOP.
    function automatic mode_t resolve_mode(input mode_t m);
        mode_t r;
        case (m)
            ONESHOT:  r = ONESHOT;
`ifdef MULTI_ADDR_SEQ_PINGPONG_EN
            PINGPONG: r = PINGPONG;
`endif
            default:  r = LOOP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/addr_seq_channel.sv
// One sequencer channel: fractional phase accumulator plus play-mode FSM.
// MULTI_ADDR_SEQ_PINGPONG_EN builds the RUN_DOWN state and subtractor.
module addr_seq_channel
    import audio_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     stop,
    input  mode_t                    mode,
    input  logic [ADDR_W+FRAC_W-1:0] step,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [ADDR_W-1:0]        end_addr,
    output logic [ADDR_W-1:0]        addr,
    output logic                     active,
    output logic                     done
);

    localparam int PW = ADDR_W + FRAC_W;

    seq_state_t        state;
    mode_t             mode_q;
    logic [PW-1:0]     phase;
    logic [PW-1:0]     step_q;
    logic [ADDR_W-1:0] lo_q;
    logic [ADDR_W-1:0] hi_q;

    logic [PW:0]       sum;
    logic              up_ok;

    assign addr = phase[PW-1:FRAC_W];

    // Upward candidate: stays in window only without carry and <= high bound.
    always_comb begin
        sum   = {1'b0, phase} + {1'b0, step_q};
        up_ok = !sum[PW] && (sum[PW-1:FRAC_W] <= hi_q);
    end

`ifdef MULTI_ADDR_SEQ_PINGPONG_EN
    logic [PW:0] diff;
    logic        dn_ok;

    // Downward candidate: stays in window only without borrow and >= low bound.
    always_comb begin
        diff  = {1'b0, phase} - {1'b0, step_q};
        dn_ok = !diff[PW] && (diff[PW-1:FRAC_W] >= lo_q);
    end
`endif

    // Channel FSM; start beats stop beats tick, outputs registered with state.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state  <= IDLE;
            mode_q <= ONESHOT;
            phase  <= '0;
            step_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mode_q <= resolve_mode(mode);
                step_q <= step;
                lo_q   <= start_addr;
                hi_q   <= end_addr;
                phase  <= {start_addr, {FRAC_W{1'b0}}};
                if (start_addr > end_addr) begin
                    state  <= IDLE;
                    active <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    state  <= RUN_UP;
                    active <= 1'b1;
                end
            end else if (stop) begin
                state  <= IDLE;
                active <= 1'b0;
            end else if (tick) begin
                case (state)
                    RUN_UP: begin
                        if (up_ok) begin
                            phase <= sum[PW-1:0];
                        end else begin
                            case (mode_q)
                                ONESHOT: begin
                                    phase  <= {hi_q, {FRAC_W{1'b0}}};
                                    state  <= IDLE;
                                    active <= 1'b0;
                                    done   <= 1'b1;
                                end
`ifdef MULTI_ADDR_SEQ_PINGPONG_EN
                                PINGPONG: begin
                                    phase <= {hi_q, {FRAC_W{1'b0}}};
                                    state <= RUN_DOWN;
                                end
`endif
                                default: begin
                                    phase <= {lo_q, {FRAC_W{1'b0}}};
                                end
                            endcase
                        end
                    end
`ifdef MULTI_ADDR_SEQ_PINGPONG_EN
                    RUN_DOWN: begin
                        if (dn_ok) begin
                            phase <= diff[PW-1:0];
                        end else begin
                            phase <= {lo_q, {FRAC_W{1'b0}}};
                            state <= RUN_UP;
                        end
                    end
`endif
                    default: begin
                        phase <= phase;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_addr_sequencer.sv
// Multi-channel wave-ROM address generator; slices buses into channels.
// MULTI_ADDR_SEQ_PINGPONG_EN enables the PINGPONG play mode.
module multi_addr_sequencer
    import audio_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              tick,
    input  logic [NUM_CH-1:0]                 ch_start,
    input  logic [NUM_CH-1:0]                 ch_stop,
    input  logic [NUM_CH*2-1:0]               ch_mode,
    input  logic [NUM_CH*(ADDR_W+FRAC_W)-1:0] ch_step,
    input  logic [NUM_CH*ADDR_W-1:0]          ch_start_addr,
    input  logic [NUM_CH*ADDR_W-1:0]          ch_end_addr,
    output logic [NUM_CH*ADDR_W-1:0]          addr,
    output logic [NUM_CH-1:0]                 active,
    output logic [NUM_CH-1:0]                 done
);

    localparam int PW = ADDR_W + FRAC_W;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        addr_seq_channel #(
            .ADDR_W (ADDR_W),
            .FRAC_W (FRAC_W)
        ) u_ch (
            .clk        (clk),
            .resetN     (resetN),
            .tick       (tick),
            .start      (ch_start[i]),
            .stop       (ch_stop[i]),
            .mode       (mode_t'(ch_mode[2*i +: 2])),
            .step       (ch_step[PW*i +: PW]),
            .start_addr (ch_start_addr[ADDR_W*i +: ADDR_W]),
            .end_addr   (ch_end_addr[ADDR_W*i +: ADDR_W]),
            .addr       (addr[ADDR_W*i +: ADDR_W]),
            .active     (active[i]),
            .done       (done[i])
        );
    end

endmodule
